// File: rtl/rom_port_arbiter.sv
// Shares one synchronous ROM port between instruction fetch and data loads, one access in flight.
// Define ROM_ARB_RR_EN for round-robin grants; by default data has fixed priority over fetch.
module rom_port_arbiter #(
  parameter int unsigned            ADDR_WIDTH   = 16,
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            WAIT_TIMEOUT = 4,
  parameter logic [DATA_WIDTH-1:0]  NOP_WORD     = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH+1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  d_req_valid,
  input  logic [ADDR_WIDTH+1:0] d_req_addr,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  d_rsp_err,
  output logic                  rom_ce,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  rom_rdata_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t     state, state_nxt;
  logic       owner_d;
  logic [3:0] cnt;
  logic       gnt_d, gnt_if, if_acc, d_acc, d_mis, timeout;
  logic       if_addr_unused;

  // Fetch byte offset is dropped on the floor: instruction words are always aligned.
  assign if_addr_unused = ^if_req_addr[1:0];

`ifdef ROM_ARB_RR_EN
  logic ptr_d;
  assign gnt_d = d_req_valid && (ptr_d || !if_req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr_d <= 1'b0;
    else if (if_acc || d_acc)  ptr_d <= if_acc;
  end
`else
  assign gnt_d = d_req_valid;
`endif

  assign gnt_if       = if_req_valid && !gnt_d;
  assign if_req_ready = (state == S_IDLE) && gnt_if;
  assign d_req_ready  = (state == S_IDLE) && gnt_d;
  assign if_acc       = if_req_valid && if_req_ready;
  assign d_acc        = d_req_valid && d_req_ready;
  assign d_mis        = d_req_addr[1:0] != 2'b00;
  assign rom_ce       = if_acc || (d_acc && !d_mis);
  assign rom_addr     = !rom_ce ? '0 :
                        d_acc   ? d_req_addr[ADDR_WIDTH+1:2] : if_req_addr[ADDR_WIDTH+1:2];
  // ROM data arriving on the last allowed cycle still counts as a hit.
  assign timeout      = (state == S_WAIT) && !rom_rdata_valid && (cnt == 4'(WAIT_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (d_acc && d_mis) state_nxt = S_ERR;
              else if (rom_ce)    state_nxt = S_WAIT;
      S_WAIT: if (rom_rdata_valid || timeout) state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      owner_d      <= 1'b0;
      cnt          <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      d_rsp_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (if_acc || d_acc) owner_d <= d_acc;
          if (d_acc && d_mis) begin
            d_rsp_valid <= 1'b1;
            d_rsp_err   <= 1'b1;
            d_rsp_data  <= '0;
          end
        end
        S_WAIT: begin
          if (rom_rdata_valid) begin
            cnt <= '0;
            if (owner_d) begin
              d_rsp_valid <= 1'b1;
              d_rsp_err   <= 1'b0;
              d_rsp_data  <= rom_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= rom_rdata;
            end
          end else if (timeout) begin
            cnt <= '0;
            if (owner_d) begin
              d_rsp_valid <= 1'b1;
              d_rsp_err   <= 1'b1;
              d_rsp_data  <= '0;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= NOP_WORD;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a one-cycle-latency ROM model that can be stalled.
module tb_rom_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW+1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [AW+1:0] d_req_addr;
  logic [DW-1:0] d_rsp_data;
  logic          rom_ce, rom_rdata_valid;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic rom_on    = 1'b1;
  logic force_vld = 1'b0;

  rom_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .rom_rdata_valid(rom_rdata_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    if (a == 16'd2) return 32'hDEADBEEF;
    return 32'h1000_0000 | 32'(a);
  endfunction

  // ROM: data one cycle after rom_ce; rom_on=0 stalls it, force_vld injects stray valids.
  always @(posedge clk) begin
    rom_rdata_valid <= (rom_on && rom_ce) || force_vld;
    rom_rdata       <= word(rom_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid  = 1'b0; d_req_addr  = '0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst_n = 1'b0; idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_vld"}, if_rsp_valid, 1'b0);
    chk({tag, "_d_vld"},  d_rsp_valid,  1'b0);
    chk({tag, "_d_err"},  d_rsp_err,    1'b0);
    chk({tag, "_if_dat"}, if_rsp_data,  '0);
    chk({tag, "_d_dat"},  d_rsp_data,   '0);
    chk({tag, "_ce"},     rom_ce,       1'b0);
    chk({tag, "_addr"},   rom_addr,     '0);
    chk({tag, "_if_rdy"}, if_req_ready, 1'b0);
    chk({tag, "_d_rdy"},  d_req_ready,  1'b0);
  endtask

  int n_d, n_if;
  logic exp_d;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk_quiet("reset");
    do_reset();

    // 1: fetch of word 2
    if_req_valid = 1'b1; if_req_addr = 18'h0008; #1;
    chk("t1_rdy", if_req_ready, 1'b1);
    chk("t1_ce", rom_ce, 1'b1);
    chk("t1_addr", rom_addr, 16'd2);
    tick(); if_req_valid = 1'b0; #1;
    chk("t1_wait_ce", rom_ce, 1'b0);
    chk("t1_wait_vld", if_rsp_valid, 1'b0);
    tick();
    chk("t1_vld", if_rsp_valid, 1'b1);
    chk("t1_dat", if_rsp_data, 32'hDEADBEEF);
    tick();
    chk("t1_pulse", if_rsp_valid, 1'b0);
    chk("t1_hold", if_rsp_data, 32'hDEADBEEF);

    // 2: misaligned data load, then a fetch must go straight through
    d_req_valid = 1'b1; d_req_addr = 18'h0006; #1;
    chk("t2_rdy", d_req_ready, 1'b1);
    chk("t2_ce", rom_ce, 1'b0);
    tick(); d_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 18'h0010; #1;
    chk("t2_vld", d_rsp_valid, 1'b1);
    chk("t2_err", d_rsp_err, 1'b1);
    chk("t2_dat", d_rsp_data, '0);
    chk("t2_err_if_rdy", if_req_ready, 1'b0);
    tick();
    chk("t2_if_rdy", if_req_ready, 1'b1);
    chk("t2_if_addr", rom_addr, 16'd4);
    chk("t2_d_pulse", d_rsp_valid, 1'b0);
    tick(); if_req_valid = 1'b0;
    tick();
    chk("t2_if_vld", if_rsp_valid, 1'b1);
    chk("t2_if_dat", if_rsp_data, 32'h1000_0004);

    // 3: both ports requesting continuously for 8 accesses
    do_reset();
    n_d = 0; n_if = 0;
    if_req_valid = 1'b1; if_req_addr = 18'h0020;
    d_req_valid  = 1'b1; d_req_addr  = 18'h0040;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_d = RR ? (i % 2 == 1) : 1'b1;
      chk("t3_d_rdy", d_req_ready, exp_d);
      chk("t3_if_rdy", if_req_ready, !exp_d);
      if (d_req_ready)  n_d++;
      if (if_req_ready) n_if++;
      tick(); tick();
      chk("t3_rsp_vld", exp_d ? d_rsp_valid : if_rsp_valid, 1'b1);
      chk("t3_rsp_dat", exp_d ? d_rsp_data : if_rsp_data, exp_d ? 32'h1000_0010 : 32'h1000_0008);
    end
    chk("t3_n_d", n_d, RR ? 4 : 8);
    chk("t3_n_if", n_if, RR ? 4 : 0);
    idle_inputs();
    tick();

    // 4: timeouts on both ports, then ROM data landing on the last wait cycle
    rom_on = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 18'h000C; #1;
    chk("t4_if_rdy", if_req_ready, 1'b1);
    tick(); if_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_if_wait", if_rsp_valid, 1'b0);
      tick();
    end
    chk("t4_if_vld", if_rsp_valid, 1'b1);
    chk("t4_if_nop", if_rsp_data, 32'h0000_0013);
    d_req_valid = 1'b1; d_req_addr = 18'h0010; #1;
    chk("t4_d_rdy", d_req_ready, 1'b1);
    tick(); d_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_d_wait", d_rsp_valid, 1'b0);
      tick();
    end
    chk("t4_d_vld", d_rsp_valid, 1'b1);
    chk("t4_d_err", d_rsp_err, 1'b1);
    chk("t4_d_dat", d_rsp_data, '0);
    d_req_valid = 1'b1; d_req_addr = 18'h0014;
    tick(); d_req_valid = 1'b0;
    tick(); tick(); force_vld = 1'b1;
    tick(); force_vld = 1'b0;
    tick();
    chk("t4_tie_vld", d_rsp_valid, 1'b1);
    chk("t4_tie_err", d_rsp_err, 1'b0);
    chk("t4_tie_dat", d_rsp_data, 32'h1000_0000);
    rom_on = 1'b1;

    // 5: reset while an access is in WAIT, with stray ROM valids around release
    if_req_valid = 1'b1; if_req_addr = 18'h0018;
    tick(); if_req_valid = 1'b0;
    rst_n = 1'b0; force_vld = 1'b1; #2;
    chk_quiet("t5_rst");
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_if_quiet", if_rsp_valid, 1'b0);
      chk("t5_d_quiet", d_rsp_valid, 1'b0);
    end
    force_vld = 1'b0;
    tick();
    if_req_valid = 1'b1; if_req_addr = 18'h0008; #1;
    chk("t5_rdy", if_req_ready, 1'b1);
    tick(); if_req_valid = 1'b0;
    tick();
    chk("t5_vld", if_rsp_valid, 1'b1);
    chk("t5_dat", if_rsp_data, 32'hDEADBEEF);

    // 6: back-to-back data reads at byte addresses 0, 4, 8
    d_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_req_addr = 18'(k * 4); #1;
      chk("t6_rdy", d_req_ready, 1'b1);
      tick(); #1;
      chk("t6_wait_rdy", d_req_ready, 1'b0);
      tick();
      chk("t6_vld", d_rsp_valid, 1'b1);
      chk("t6_dat", d_rsp_data, word(16'(k)));
      if (k == 2) d_req_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
